// File: rtl/lcd_spi_mon_pkg.sv
// Shared types and constants for the LCD SPI bus monitor.
package lcd_spi_mon_pkg;

  // Flops in each input synchroniser chain.
  localparam int unsigned SyncStages = 2;

  // One captured LCD byte with its data/command tag (1 = data, 0 = command).
  typedef struct packed {
    logic       is_data;
    logic [7:0] value;
  } lcd_byte_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } mon_state_e;

endpackage

// File: rtl/lcd_spi_mon_fifo.sv
// Small FIFO of captured LCD bytes.
// The head is read straight from the storage registers.
// Pointers carry one extra wrap bit to tell full from empty.
module lcd_spi_mon_fifo
  import lcd_spi_mon_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  lcd_byte_t push_data_i,
  input  logic      pop_i,
  output lcd_byte_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  lcd_byte_t      mem_q [FifoDepth];
  lcd_byte_t      mem_d [FifoDepth];
  logic           do_push;
  logic           do_pop;

  // Status flags, accept decisions and next-state for pointers and storage.
  // A pop frees the slot that a push on a full FIFO reuses in the same cycle.
  always_comb begin
    full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
               (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    empty_o  = (wr_ptr_q == rd_ptr_q);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    head_o   = mem_q[rd_ptr_q[AddrW-1:0]];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = push_data_i;
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pointer and storage registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/lcd_spi_monitor.sv
// Passive monitor for the LCD SPI bus (mode 0, MSB first).
// Reconstructs bytes, tags them with the DC line, and queues them behind valid/ready.
// Optional macro LCD_SPI_MON_STATS_EN builds the command/data/frame-error counters.
// Pipeline: 2 sync flops, registered edge detect, shift/push register, FIFO write.
module lcd_spi_monitor
  import lcd_spi_mon_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned CntW      = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            spi_sck_i,
  input  logic            spi_cs_ni,
  input  logic            spi_copi_i,
  input  logic            lcd_dc_i,
  output logic            byte_valid_o,
  input  logic            byte_ready_i,
  output logic [7:0]      byte_value_o,
  output logic            byte_is_data_o,
  output logic            overflow_o,
  output logic            frame_err_pulse_o,
  output logic [CntW-1:0] cmd_count_o,
  output logic [CntW-1:0] data_count_o
);

  logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
  logic [SyncStages-1:0] cs_sync_q, cs_sync_d;
  logic [SyncStages-1:0] copi_sync_q, copi_sync_d;
  logic [SyncStages-1:0] dc_sync_q, dc_sync_d;

  logic sck_dly_q, sck_dly_d;
  logic rise_q, rise_d;
  logic cs_q, cs_d;
  logic copi_q, copi_d;
  logic dc_q, dc_d;

  mon_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       push_q, push_d;
  lcd_byte_t  push_byte_q, push_byte_d;
  logic       frame_err_q, frame_err_d;
  logic       overflow_q, overflow_d;

  lcd_byte_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  // Synchroniser chains, SCK delayed copy, and the aligned edge-detect stage.
  // COPI/DC/CS are delayed alongside the edge flag so the FSM sees them in step.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SyncStages-2:0], spi_sck_i};
    cs_sync_d   = {cs_sync_q[SyncStages-2:0], spi_cs_ni};
    copi_sync_d = {copi_sync_q[SyncStages-2:0], spi_copi_i};
    dc_sync_d   = {dc_sync_q[SyncStages-2:0], lcd_dc_i};
    sck_dly_d   = sck_sync_q[SyncStages-1];
    rise_d      = sck_sync_q[SyncStages-1] && !sck_dly_q;
    cs_d        = cs_sync_q[SyncStages-1];
    copi_d      = copi_sync_q[SyncStages-1];
    dc_d        = dc_sync_q[SyncStages-1];
  end

  // Input capture registers; CS idles high so reset does not look like a frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
      dc_sync_q   <= '0;
      sck_dly_q   <= 1'b0;
      rise_q      <= 1'b0;
      cs_q        <= 1'b1;
      copi_q      <= 1'b0;
      dc_q        <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      copi_sync_q <= copi_sync_d;
      dc_sync_q   <= dc_sync_d;
      sck_dly_q   <= sck_dly_d;
      rise_q      <= rise_d;
      cs_q        <= cs_d;
      copi_q      <= copi_d;
      dc_q        <= dc_d;
    end
  end

  // Framing FSM: shift bits while CS is low, emit a byte every 8th edge, flag short frames.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!cs_q) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_q) begin
          state_d     = IDLE;
          cnt_d       = '0;
          frame_err_d = (cnt_q != 3'd0);
        end else if (rise_q) begin
          shreg_d = {shreg_q[6:0], copi_q};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            push_d              = 1'b1;
            push_byte_d.is_data = dc_q;
            push_byte_d.value   = {shreg_q[6:0], copi_q};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, shifter, byte handoff and error pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  lcd_spi_mon_fifo #(
    .FifoDepth (FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_q),
    .push_data_i (push_byte_q),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Handshake and sticky overflow: a push onto a full FIFO is lost unless a pop frees a slot.
  always_comb begin
    pop        = !fifo_empty && byte_ready_i;
    overflow_d = overflow_q || (push_q && fifo_full && !pop);
  end

  // Sticky overflow register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign byte_valid_o      = !fifo_empty;
  assign byte_value_o      = head.value;
  assign byte_is_data_o    = head.is_data;
  assign overflow_o        = overflow_q;
  assign frame_err_pulse_o = frame_err_q;

`ifdef LCD_SPI_MON_STATS_EN
  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

  logic [CntW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [CntW-1:0] data_cnt_q, data_cnt_d;
  logic [CntW-1:0] err_cnt_q, err_cnt_d;

  // Statistics: every emitted byte counts, including ones dropped on overflow.
  always_comb begin
    cmd_cnt_d  = cmd_cnt_q;
    data_cnt_d = data_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (push_q && push_byte_q.is_data) begin
      data_cnt_d = data_cnt_q + CntOne;
    end
    if (push_q && !push_byte_q.is_data) begin
      cmd_cnt_d = cmd_cnt_q + CntOne;
    end
    if (frame_err_q) begin
      err_cnt_d = err_cnt_q + CntOne;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      cmd_cnt_q  <= cmd_cnt_d;
      data_cnt_q <= data_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign cmd_count_o  = cmd_cnt_q;
  assign data_count_o = data_cnt_q;
`else
  assign cmd_count_o  = '0;
  assign data_count_o = '0;
`endif

endmodule

// File: tb/tb_lcd_spi_monitor.sv
// Directed bench for lcd_spi_monitor with a byte scoreboard checked on every pop.
module tb_lcd_spi_monitor;

`ifdef LCD_SPI_MON_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        copi = 1'b0;
  logic        dc = 1'b0;
  logic        ready = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_value;
  logic        byte_is_data;
  logic        overflow;
  logic        frame_err;
  logic [15:0] cmd_count;
  logic [15:0] data_count;

  int total = 0;
  int bad = 0;
  int cmd_exp = 0;
  int data_exp = 0;
  logic [8:0] sb [$];

  lcd_spi_monitor #(
    .FifoDepth (4),
    .CntW      (16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .spi_sck_i         (sck),
    .spi_cs_ni         (cs_n),
    .spi_copi_i        (copi),
    .lcd_dc_i          (dc),
    .byte_valid_o      (byte_valid),
    .byte_ready_i      (ready),
    .byte_value_o      (byte_value),
    .byte_is_data_o    (byte_is_data),
    .overflow_o        (overflow),
    .frame_err_pulse_o (frame_err),
    .cmd_count_o       (cmd_count),
    .data_count_o      (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && byte_valid && ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL pop_extra observed=%0h expected=none", {byte_is_data, byte_value});
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("pop_byte", {23'b0, byte_is_data, byte_value}, {23'b0, e});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    copi = b;
    tick(4);
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d, input bit keep);
    dc = d;
    if (keep) sb.push_back({d, v});
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    if (d) data_exp++;
    else cmd_exp++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || byte_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_valid_low"}, {31'b0, byte_valid}, 0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_cmd_count"}, {16'b0, cmd_count}, StatsEn ? cmd_exp : 0);
    chk({tag, "_data_count"}, {16'b0, data_count}, StatsEn ? data_exp : 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, byte_valid}, 0);
    chk({tag, "_value"}, {24'b0, byte_value}, 0);
    chk({tag, "_is_data"}, {31'b0, byte_is_data}, 0);
    chk({tag, "_overflow"}, {31'b0, overflow}, 0);
    chk({tag, "_frame_err"}, {31'b0, frame_err}, 0);
    chk({tag, "_cmd_count"}, {16'b0, cmd_count}, 0);
    chk({tag, "_data_count"}, {16'b0, data_count}, 0);
  endtask

  initial begin
    int pulses;
    logic [7:0] v;

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);
    cs_n = 1'b0;
    tick(4);

    // Single command byte 0x2A with latency measurement on the last edge
    ready = 1'b1;
    dc = 1'b0;
    v = 8'h2A;
    sb.push_back({1'b0, v});
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    copi = v[0];
    tick(4);
    sck = 1'b1;
    repeat (5) @(negedge clk);
    chk("lat_edge3_valid", {31'b0, byte_valid}, 0);
    @(negedge clk);
    chk("lat_edge4_valid", {31'b0, byte_valid}, 1);
    chk("lat_edge4_value", {24'b0, byte_value}, 32'h2A);
    tick(3);
    sck = 1'b0;
    cmd_exp++;
    drain("t1");
    check_counts("t1");

    // Burst of three data bytes held back, then drained on consecutive cycles
    tick(1);
    ready = 1'b0;
    send_byte(8'h12, 1'b1, 1'b1);
    send_byte(8'h34, 1'b1, 1'b1);
    send_byte(8'h56, 1'b1, 1'b1);
    tick(6);
    chk("burst_head_valid", {31'b0, byte_valid}, 1);
    chk("burst_head_value", {24'b0, byte_value}, 32'h12);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("burst_pop_valid", {31'b0, byte_valid}, 1);
    end
    @(negedge clk);
    chk("burst_after_valid", {31'b0, byte_valid}, 0);
    chk("burst_overflow", {31'b0, overflow}, 0);
    check_counts("t2");

    // Full FIFO with a pop coinciding with the fifth push
    tick(1);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b1);
    dc = 1'b0;
    v = 8'hA4;
    sb.push_back({1'b0, v});
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    copi = v[0];
    tick(4);
    sck = 1'b1;
    repeat (4) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    tick(3);
    sck = 1'b0;
    cmd_exp++;
    @(negedge clk);
    chk("simul_overflow", {31'b0, overflow}, 0);
    chk("simul_head_value", {24'b0, byte_value}, 32'hA1);
    tick(1);
    ready = 1'b1;
    drain("t5");
    chk("simul_overflow_after", {31'b0, overflow}, 0);
    check_counts("t5");

    // Six bytes into a four-deep FIFO: last two dropped, overflow sticky
    tick(1);
    ready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i), 1'b1, i < 4);
    tick(6);
    chk("ovf_set", {31'b0, overflow}, 1);
    ready = 1'b1;
    drain("t3");
    chk("ovf_sticky", {31'b0, overflow}, 1);
    check_counts("t3");

    // CS raised after five bits: one-cycle error pulse, nothing pushed
    tick(1);
    dc = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    tick(2);
    cs_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (frame_err) pulses++;
    end
    chk("ferr_pulse_cycles", pulses, 1);
    chk("ferr_no_push", {31'b0, byte_valid}, 0);
    tick(2);
    cs_n = 1'b0;
    tick(4);
    send_byte(8'h81, 1'b1, 1'b1);
    drain("t4");
    check_counts("t4");

    // Asynchronous reset mid-byte with two bytes queued
    tick(1);
    ready = 1'b0;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    tick(6);
    chk("prereset_valid", {31'b0, byte_valid}, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    #3 rst = 1'b1;
    #2;
    check_all_zero("async_reset");
    cmd_exp = 0;
    data_exp = 0;
    cs_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    cs_n = 1'b0;
    tick(4);
    ready = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b1);
    drain("t6");
    check_counts("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
